// File: rtl/vend_arbiter.sv
// Coin-credit vending arbiter: per-slot saturating credit counters feeding a
// round-robin grant of a single dispenser with a fixed occupancy time.
module vend_arbiter #(
    parameter int unsigned NUM_SLOTS       = 4,
    parameter int unsigned PRICE           = 3,
    parameter int unsigned CREDIT_W        = 4,
    parameter int unsigned DISPENSE_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SLOTS-1:0]          coin,
    input  logic                          vend_en,
    output logic [NUM_SLOTS-1:0]          grant,
    output logic                          valid,
    output logic                          busy,
    output logic [NUM_SLOTS*CREDIT_W-1:0] credit,
    output logic [NUM_SLOTS-1:0]          lost
);

    localparam int unsigned PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned CNT_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
    localparam logic [CREDIT_W:0]   SAT_MAX   = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [CREDIT_W:0]   PRICE_EXT = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_CMP = CREDIT_W'(PRICE);
    localparam logic [PTR_W-1:0]    PTR_RST   = PTR_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0]    CNT_LOAD  = CNT_W'(DISPENSE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [NUM_SLOTS-1:0]  r_grant;
    logic                  r_valid;
    logic [PTR_W-1:0]      r_ptr;
    logic [CNT_W-1:0]      r_cnt;
    logic [CREDIT_W-1:0]   r_credit [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  r_lost;

    state_t                w_state_nxt;
    logic [NUM_SLOTS-1:0]  w_grant_nxt;
    logic                  w_valid_nxt;
    logic [PTR_W-1:0]      w_ptr_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [NUM_SLOTS-1:0]  w_win_vec;
    logic [NUM_SLOTS-1:0]  w_elig;
    logic                  w_found;
    logic [PTR_W-1:0]      w_win_idx;
    logic [PTR_W-1:0]      w_probe;
    logic [CREDIT_W:0]     w_sum        [NUM_SLOTS];
    logic [CREDIT_W-1:0]   w_credit_nxt [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  w_lost_set;

    // Eligibility looks only at registered credit, so a coin lands one edge before it can win.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_elig[i] = (r_credit[i] >= PRICE_CMP);
        end
    end

    // Round-robin search starting one past the last winner.
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        w_probe   = '0;
        for (int unsigned k = 1; k <= NUM_SLOTS; k++) begin
            w_probe = PTR_W'((32'(r_ptr) + k) % NUM_SLOTS);
            if (!w_found && w_elig[w_probe]) begin
                w_found   = 1'b1;
                w_win_idx = w_probe;
            end
        end
    end

    // FSM next-state and registered-output values.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_valid_nxt = r_valid;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_win_vec   = '0;
        case (r_state)
            IDLE: begin
                if (vend_en && w_found) begin
                    w_state_nxt = BUSY;
                    w_win_vec   = NUM_SLOTS'(1) << w_win_idx;
                    w_grant_nxt = NUM_SLOTS'(1) << w_win_idx;
                    w_ptr_nxt   = w_win_idx;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_state_nxt = DONE;
                    w_valid_nxt = 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
                w_grant_nxt = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
                w_grant_nxt = '0;
            end
        endcase
    end

    // Credit update at one extra bit; the winner's deduction keeps its own coin from overflowing.
    always_comb begin
        w_lost_set = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_sum[i] = {1'b0, r_credit[i]} + (CREDIT_W+1)'(coin[i])
                       - (w_win_vec[i] ? PRICE_EXT : (CREDIT_W+1)'(0));
            w_credit_nxt[i] = w_sum[i][CREDIT_W-1:0];
            if (w_sum[i] > SAT_MAX) begin
                w_credit_nxt[i] = SAT_MAX[CREDIT_W-1:0];
                w_lost_set[i]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_valid <= 1'b0;
            r_ptr   <= PTR_RST;
            r_cnt   <= '0;
            r_lost  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_credit[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_valid <= w_valid_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lost  <= r_lost | w_lost_set;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_credit[i] <= w_credit_nxt[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_credit_out
        assign credit[g*CREDIT_W +: CREDIT_W] = r_credit[g];
    end

    assign grant = r_grant;
    assign valid = r_valid;
    assign busy  = (r_state != IDLE);
    assign lost  = r_lost;

endmodule

// File: tb/tb_vend_arbiter.sv
// Directed scenario bench for vend_arbiter with default parameters
// (4 slots, price 3, 4-bit credits, 2 dispense cycles).
module tb_vend_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  coin;
    logic        vend_en;
    logic [3:0]  grant;
    logic        valid;
    logic        busy;
    logic [15:0] credit;
    logic [3:0]  lost;

    int n_pass  = 0;
    int n_total = 0;

    vend_arbiter dut (
        .clk     (clk),
        .reset   (reset),
        .coin    (coin),
        .vend_en (vend_en),
        .grant   (grant),
        .valid   (valid),
        .busy    (busy),
        .credit  (credit),
        .lost    (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] cr(input int i);
        return credit[i*4 +: 4];
    endfunction

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        coin    = 4'b0;
        vend_en = 1'b0;
        reset   = 1'b1;
        tick();
        tick();
        reset   = 1'b0;
    endtask

    task automatic test_reset();
        coin    = 4'b0;
        vend_en = 1'b0;
        reset   = 1'b1;
        #3;
        n_total++;
        if ({grant, valid, busy, credit, lost} !== 26'b0)
            $display("FAIL reset_outputs got=%h exp=0", {grant, valid, busy, credit, lost});
        else n_pass++;
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_total++;
        if ({grant, busy} !== 5'b0)
            $display("FAIL reset_first_edge got=%b exp=00000", {grant, busy});
        else n_pass++;
    endtask

    task automatic test_single_vend();
        logic [3:0] exp_g [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
        logic       exp_v [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        apply_reset();
        vend_en = 1'b1;
        coin    = 4'b0001;
        tick();
        tick();
        tick();
        coin = 4'b0;
        n_total++;
        if (grant !== 4'b0 || cr(0) !== 4'd3)
            $display("FAIL single_loaded grant=%b credit0=%0d exp grant=0000 credit0=3", grant, cr(0));
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_total++;
            if (grant !== exp_g[c] || valid !== exp_v[c])
                $display("FAIL single_cycle%0d grant=%b valid=%b exp grant=%b valid=%b",
                         c, grant, valid, exp_g[c], exp_v[c]);
            else n_pass++;
        end
        n_total++;
        if (cr(0) !== 4'd0 || busy !== 1'b0)
            $display("FAIL single_end credit0=%0d busy=%b exp 0 0", cr(0), busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_g [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000,
                                  4'b0100, 4'b0100, 4'b0100, 4'b0000};
        logic       exp_v [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int         n_valid = 0;
        apply_reset();
        coin = 4'b0101;
        tick();
        tick();
        tick();
        coin = 4'b0;
        tick();
        n_total++;
        if (grant !== 4'b0 || cr(0) !== 4'd3 || cr(2) !== 4'd3)
            $display("FAIL b2b_hold grant=%b c0=%0d c2=%0d exp 0000 3 3", grant, cr(0), cr(2));
        else n_pass++;
        vend_en = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (valid === 1'b1) n_valid++;
            n_total++;
            if (grant !== exp_g[c] || valid !== exp_v[c])
                $display("FAIL b2b_cycle%0d grant=%b valid=%b exp grant=%b valid=%b",
                         c, grant, valid, exp_g[c], exp_v[c]);
            else n_pass++;
        end
        n_total++;
        if (n_valid != 2 || cr(0) !== 4'd0 || cr(2) !== 4'd0)
            $display("FAIL b2b_end valids=%0d c0=%0d c2=%0d exp 2 0 0", n_valid, cr(0), cr(2));
        else n_pass++;
        vend_en = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        apply_reset();
        coin = 4'b1111;
        for (int c = 0; c < 15; c++) tick();
        coin = 4'b0;
        n_total++;
        if (credit !== 16'hFFFF || lost !== 4'b0)
            $display("FAIL rr_full credit=%h lost=%b exp FFFF 0000", credit, lost);
        else n_pass++;
        vend_en = 1'b1;
        for (int v = 0; v < 5; v++) begin
            tick();
            n_total++;
            if (grant !== exp_g[v])
                $display("FAIL rr_grant%0d got=%b exp=%b", v, grant, exp_g[v]);
            else n_pass++;
            if (v == 3) begin
                n_total++;
                if (credit !== 16'hCCCC)
                    $display("FAIL rr_round_credit got=%h exp=CCCC", credit);
                else n_pass++;
            end
            tick();
            tick();
            tick();
        end
        n_total++;
        if (credit !== 16'hCCC9)
            $display("FAIL rr_end_credit got=%h exp=CCC9", credit);
        else n_pass++;
        vend_en = 1'b0;
    endtask

    task automatic test_coin_on_win();
        apply_reset();
        coin = 4'b0010;
        tick();
        tick();
        tick();
        coin = 4'b0;
        tick();
        vend_en = 1'b1;
        coin    = 4'b0010;
        tick();
        coin    = 4'b0;
        vend_en = 1'b0;
        n_total++;
        if (grant !== 4'b0010 || cr(1) !== 4'd1 || lost !== 4'b0)
            $display("FAIL coin_on_win grant=%b credit1=%0d lost=%b exp 0010 1 0000",
                     grant, cr(1), lost);
        else n_pass++;
        tick();
        tick();
        n_total++;
        if (valid !== 1'b1 || grant !== 4'b0010)
            $display("FAIL coin_on_win_done valid=%b grant=%b exp 1 0010", valid, grant);
        else n_pass++;
        tick();
    endtask

    task automatic test_saturate();
        int n_grant = 0;
        apply_reset();
        coin = 4'b1000;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (grant !== 4'b0) n_grant++;
        end
        coin = 4'b0;
        n_total++;
        if (cr(3) !== 4'd15 || lost !== 4'b1000)
            $display("FAIL sat_credit credit3=%0d lost=%b exp 15 1000", cr(3), lost);
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (grant !== 4'b0) n_grant++;
        end
        n_total++;
        if (n_grant != 0 || lost !== 4'b1000 || cr(3) !== 4'd15)
            $display("FAIL sat_hold grants=%0d lost=%b credit3=%0d exp 0 1000 15",
                     n_grant, lost, cr(3));
        else n_pass++;
    endtask

    task automatic test_reset_mid_dispense();
        int n_bad = 0;
        apply_reset();
        coin = 4'b1001;
        for (int c = 0; c < 16; c++) tick();
        coin    = 4'b0;
        vend_en = 1'b1;
        tick();
        n_total++;
        if (grant !== 4'b0001 || busy !== 1'b1 || lost !== 4'b1001 || cr(0) !== 4'd12)
            $display("FAIL mid_setup grant=%b busy=%b lost=%b c0=%0d exp 0001 1 1001 12",
                     grant, busy, lost, cr(0));
        else n_pass++;
        reset = 1'b1;
        #2;
        n_total++;
        if ({grant, valid, busy, credit, lost} !== 26'b0)
            $display("FAIL mid_async got=%h exp=0", {grant, valid, busy, credit, lost});
        else n_pass++;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (valid !== 1'b0 || grant !== 4'b0) n_bad++;
        end
        n_total++;
        if (n_bad != 0 || credit !== 16'h0)
            $display("FAIL mid_after bad_cycles=%0d credit=%h exp 0 0000", n_bad, credit);
        else n_pass++;
        vend_en = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        coin    = 4'b0;
        vend_en = 1'b0;
        test_reset();
        test_single_vend();
        test_back_to_back();
        test_round_robin();
        test_coin_on_win();
        test_saturate();
        test_reset_mid_dispense();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vend_arbiter.md
VEND_ARBITER -- requirements
Module: vend_arbiter

Interface
REQ-001: The block SHALL have parameter NUM_SLOTS, default 4, giving the number of coin slots (requesters).
REQ-002: The block SHALL have parameter PRICE, default 3, giving the coins deducted per vend; legal range 1..2^CREDIT_W-1.
REQ-003: The block SHALL have parameter CREDIT_W, default 4, giving the width of each slot credit counter.
REQ-004: The block SHALL have parameter DISPENSE_CYCLES, default 2, giving the dispenser occupancy per vend; legal range >=1.
REQ-005: The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006: The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007: The block SHALL have port coin, input, NUM_SLOTS bits: bit i high for one sampled cycle = one coin on slot i.
REQ-008: The block SHALL have port vend_en, input, 1 bit: high permits new grants; low means service hold, with coins still counted.
REQ-009: The block SHALL have port grant, output, NUM_SLOTS bits: one-hot owner of the dispenser, registered.
REQ-010: The block SHALL have port valid, output, 1 bit: one-cycle dispense strobe, registered.
REQ-011: The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-012: The block SHALL have port credit, output, NUM_SLOTS*CREDIT_W bits: slot i credit at bits [i*CREDIT_W +: CREDIT_W].
REQ-013: The block SHALL have port lost, output, NUM_SLOTS bits: sticky flag per slot set when a coin is dropped at saturation.

Function
REQ-014: The block SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-015: A slot SHALL be eligible when its credit >= PRICE.
REQ-016: In IDLE with vend_en=1 and at least one eligible slot, the block SHALL choose a winner round-robin: search starts at ptr+1 and wraps modulo NUM_SLOTS.
REQ-017: On the edge that chooses a winner w, the block SHALL set state<=BUSY, grant<=onehot(w), ptr<=w and cnt<=DISPENSE_CYCLES-1, and deduct PRICE from credit[w].
REQ-018: In BUSY with cnt!=0, cnt SHALL decrement each edge and grant SHALL hold.
REQ-019: In BUSY with cnt==0, the next edge SHALL set state<=DONE and valid<=1.
REQ-020: In DONE, the next edge SHALL set state<=IDLE, valid<=0 and grant<=0; arbitration SHALL NOT occur in DONE.
REQ-021: Latency SHALL be: grant high for DISPENSE_CYCLES+1 cycles, with valid high only in the last of them; the minimum gap between successive grants is 1 IDLE cycle.
REQ-022: No grant SHALL be issued while vend_en=0; a dispense already in progress SHALL complete regardless of vend_en.
REQ-023: Per slot, the credit update SHALL be credit + coin - (PRICE if won this edge), computed at CREDIT_W+1 bits, then saturated at 2^CREDIT_W-1.
REQ-024: A coin arriving on the same edge as a deduction for that slot SHALL be counted, never lost.
REQ-025: If a coin would push a credit above 2^CREDIT_W-1, the credit SHALL stay at the maximum and lost[i] SHALL set; lost[i] SHALL clear only on reset.
REQ-026: Coins SHALL be accepted on all slots in every state, simultaneously.
REQ-027: A coin arriving on the edge a slot becomes eligible SHALL be visible to arbitration on the following edge, not the same edge.
REQ-028: grant SHALL be zero or one-hot at all times.

Reset
REQ-029: While reset=1, without waiting for a clock edge, the block SHALL force state=IDLE, grant=0, valid=0, busy=0, all credits=0, lost=0 and ptr=NUM_SLOTS-1.
REQ-030: Reset asserted mid-dispense SHALL abort the dispense with no valid strobe and no credit restored.
REQ-031: With ptr=NUM_SLOTS-1, the first arbitration after reset SHALL start its search at slot 0.
REQ-032: The first edge after reset deasserts SHALL be treated as IDLE with zero credits.

Verification
REQ-033: Scenario: one coin pulse on slot 0 in each of 3 cycles, vend_en=1 -> grant=0001 one edge later, held 3 cycles; valid=1 in the 3rd cycle only; credit0=0.
REQ-034: Scenario: slots 0 and 2 each loaded to credit 3 with vend_en=0, then vend_en=1 -> slot 0 served first, then slot 2; two valid pulses; both credits end at 0.
REQ-035: Scenario: all 4 slots at credit 15 and vend_en=1 -> grant order 0001, 0010, 0100, 1000, 0001; each credit ends at 12 after the first round.
REQ-036: Scenario: slot 1 at credit 3 with a coin on slot 1 on the winning edge -> credit1=1 afterwards.
REQ-037: Scenario: vend_en=0 and 16 coins on slot 3 -> credit3=15 and lost=1000; no grant is ever issued.
REQ-038: Scenario: reset pulsed during BUSY -> grant, valid, busy, credits and lost all read 0 before the next clock edge, and no valid strobe follows.
